// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch unit and the decode/execute stages that consume its IR.
package instruction_fetch_pkg;

  localparam int unsigned IF_AW = 4;
  localparam int unsigned IF_DW = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } if_state_e;

  // Opcode field values interpreted downstream of fetch
  localparam logic [6:0] OP_ADD  = 7'b0000010;
  localparam logic [6:0] OP_DEC  = 7'b0000110;
  localparam logic [6:0] OP_LOAD = 7'b0010000;
  localparam logic [6:0] OP_ADDI = 7'b1000010;
  localparam logic [6:0] OP_BRZ  = 7'b1100000;
  localparam logic [6:0] OP_JUMP = 7'b1110000;

endpackage

// File: rtl/instruction_fetch_counter.sv
// Saturating event counter with synchronous clear; clear wins over enable.
module instruction_fetch_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the instruction SRAM port, holds the PC and presents a
// registered IR to decode over valid/ready; the loader owns the SRAM while idle.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned AW       = IF_AW,
  parameter int unsigned DW       = IF_DW,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             LD_EN,
  input  logic [AW-1:0]    LD_ADDR,
  input  logic [DW-1:0]    LD_DATA,
  output logic [AW-1:0]    IM_A,
  output logic             IM_WR,
  output logic [DW-1:0]    IM_D,
  input  logic [DW-1:0]    IM_Q,
  output logic [DW-1:0]    IR,
  output logic [AW-1:0]    IR_PC,
  output logic             IR_VALID,
  input  logic             IR_READY,
  input  logic             BR_TAKEN,
  input  logic [AW-1:0]    BR_TARGET,
  output logic             BUSY,
  output logic [CNT_W-1:0] FETCH_CNT
);

  if_state_e      state_d, state_q;
  logic [AW-1:0]  pc_d, pc_q;
  logic [DW-1:0]  ir_d, ir_q;
  logic [AW-1:0]  ir_pc_d, ir_pc_q;
  logic           ir_valid_d, ir_valid_q;
  logic           busy_d, busy_q;
  logic           fire;
  logic           cnt_clr;

  // Next-state: redirect beats stop, stop beats fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    fire       = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          pc_d    = AW'(RESET_PC);
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (BR_TAKEN) begin
          pc_d       = BR_TARGET;
          ir_valid_d = 1'b0;
          if (STOP) state_d = ST_IDLE;
        end else if (STOP) begin
          if (IR_READY) ir_valid_d = 1'b0;
          state_d = ir_valid_d ? ST_DRAIN : ST_IDLE;
        end else if (!ir_valid_q || IR_READY) begin
          fire       = 1'b1;
          ir_d       = IM_Q;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (BR_TAKEN) begin
          pc_d       = BR_TARGET;
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (IR_READY) begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pc_q       <= AW'(RESET_PC);
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
    end
  end

  instruction_fetch_counter #(
    .W (CNT_W)
  ) u_fetch_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .en    (fire),
    .cnt   (FETCH_CNT)
  );

  // SRAM port: loader address while idle, PC otherwise; START suppresses a loader write
  assign IM_A  = (state_q == ST_IDLE) ? LD_ADDR : pc_q;
  assign IM_WR = (state_q == ST_IDLE) && LD_EN && !START;
  assign IM_D  = LD_DATA;

  assign IR       = ir_q;
  assign IR_PC    = ir_pc_q;
  assign IR_VALID = ir_valid_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: 16x13 SRAM model, vector table for the main flow, hand sequences for reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, ld_en, ir_ready, br_taken;
  logic [3:0]  ld_addr, br_target;
  logic [12:0] ld_data;

  logic [3:0]  im_a, ir_pc, im_a2, ir_pc2;
  logic        im_wr, ir_valid, busy, im_wr2, ir_valid2, busy2;
  logic [12:0] im_d, im_q, ir, im_d2, im_q2, ir2;
  logic [7:0]  fetch_cnt;
  logic [1:0]  fetch_cnt2;

  logic [12:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.AW(4), .DW(13), .RESET_PC(0), .CNT_W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .LD_EN(ld_en),
    .LD_ADDR(ld_addr), .LD_DATA(ld_data), .IM_A(im_a), .IM_WR(im_wr), .IM_D(im_d),
    .IM_Q(im_q), .IR(ir), .IR_PC(ir_pc), .IR_VALID(ir_valid), .IR_READY(ir_ready),
    .BR_TAKEN(br_taken), .BR_TARGET(br_target), .BUSY(busy), .FETCH_CNT(fetch_cnt)
  );

  // Narrow-counter instance reads the same memory to exercise saturation
  instruction_fetch #(.AW(4), .DW(13), .RESET_PC(0), .CNT_W(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .LD_EN(ld_en),
    .LD_ADDR(ld_addr), .LD_DATA(ld_data), .IM_A(im_a2), .IM_WR(im_wr2), .IM_D(im_d2),
    .IM_Q(im_q2), .IR(ir2), .IR_PC(ir_pc2), .IR_VALID(ir_valid2), .IR_READY(ir_ready),
    .BR_TAKEN(br_taken), .BR_TARGET(br_target), .BUSY(busy2), .FETCH_CNT(fetch_cnt2)
  );

  assign im_q  = mem[im_a];
  assign im_q2 = mem[im_a2];

  always @(posedge clk) begin
    if (im_wr) mem[im_a] <= im_d;
  end

  typedef struct {
    logic        start, stop, ld;
    logic [3:0]  la;
    logic [12:0] ldd;
    logic        rdy, br;
    logic [3:0]  tgt;
    logic        wr;
    logic [3:0]  a;
    logic        v;
    logic [12:0] ir;
    logic [3:0]  pc;
    logic        busy;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] word(input int a);
    if (a == 0) return 13'h0A5;
    if (a == 1) return 13'h1FF;
    if (a == 2) return 13'h003;
    return 13'(a * 'h111);
  endfunction

  function automatic vec_t mk(input int st, sp, ld, la, ldd, rdy, br, tgt, wr, a, v, irv, pc, bz, cnt, cnt2);
    vec_t r;
    r.start = 1'(st); r.stop = 1'(sp); r.ld = 1'(ld); r.la = 4'(la); r.ldd = 13'(ldd);
    r.rdy = 1'(rdy); r.br = 1'(br); r.tgt = 4'(tgt); r.wr = 1'(wr); r.a = 4'(a);
    r.v = 1'(v); r.ir = 13'(irv); r.pc = 4'(pc); r.busy = 1'(bz);
    r.cnt = 8'(cnt); r.cnt2 = 2'(cnt2);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    start = t.start; stop = t.stop; ld_en = t.ld; ld_addr = t.la; ld_data = t.ldd;
    ir_ready = t.rdy; br_taken = t.br; br_target = t.tgt;
    #1;
    chk($sformatf("v%0d.im_wr", idx), 32'(im_wr), 32'(t.wr));
    chk($sformatf("v%0d.im_wr2", idx), 32'(im_wr2), 32'(t.wr));
    chk($sformatf("v%0d.im_a", idx), 32'(im_a), 32'(t.a));
    chk($sformatf("v%0d.im_d", idx), 32'(im_d), 32'(t.ldd));
    chk($sformatf("v%0d.im_d2", idx), 32'(im_d2), 32'(t.ldd));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.ir_valid", idx), 32'(ir_valid), 32'(t.v));
    chk($sformatf("v%0d.ir_valid2", idx), 32'(ir_valid2), 32'(t.v));
    chk($sformatf("v%0d.busy", idx), 32'(busy), 32'(t.busy));
    chk($sformatf("v%0d.busy2", idx), 32'(busy2), 32'(t.busy));
    chk($sformatf("v%0d.fetch_cnt", idx), 32'(fetch_cnt), 32'(t.cnt));
    chk($sformatf("v%0d.fetch_cnt2", idx), 32'(fetch_cnt2), 32'(t.cnt2));
    if (t.v) begin
      chk($sformatf("v%0d.ir", idx), 32'(ir), 32'(t.ir));
      chk($sformatf("v%0d.ir_pc", idx), 32'(ir_pc), 32'(t.pc));
      chk($sformatf("v%0d.ir2", idx), 32'(ir2), 32'(t.ir));
      chk($sformatf("v%0d.ir_pc2", idx), 32'(ir_pc2), 32'(t.pc));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stop = 0; ld_en = 0; ir_ready = 0; br_taken = 0;
    ld_addr = '0; br_target = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ir_valid", 32'(ir_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.ir", 32'(ir), 0);
    chk("rst.ir_pc", 32'(ir_pc), 0);
    chk("rst.fetch_cnt", 32'(fetch_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program load through the loader port
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'(a); ld_data = word(a);
      #1;
      chk($sformatf("ld%0d.im_wr", a), 32'(im_wr), 1);
      chk($sformatf("ld%0d.im_a", a), 32'(im_a), 32'(a));
    end
    @(negedge clk);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int a = 0; a < 16; a++) chk($sformatf("mem%0d", a), 32'(mem[a]), 32'(word(a)));

    //              st sp ld la ldd     rdy br tgt wr a   v  ir        pc bz cnt c2
    vecs.push_back(mk(1, 0, 0, 0, 0,      1, 0, 0,  0, 0,  0, 0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 0,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 1,  1, 'h1FF,    1, 1, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 2,  1, 'h003,    2, 1, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 1, 11, 0, 3,  0, 0,        0, 1, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 11, 1, word(11), 11, 1, 4, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 12, 1, word(12), 12, 1, 5, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 13, 1, word(13), 13, 1, 6, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 14, 1, word(14), 14, 1, 7, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 15, 1, word(15), 15, 1, 8, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 0,  1, 'h0A5,    0, 1, 9, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 9, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 9, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 1,  0, 0,        0, 0, 9, 3));
    vecs.push_back(mk(1, 0, 1, 5, 'h1ABC, 0, 0, 0,  0, 5,  0, 0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0,  0, 0,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,      1, 0, 0,  0, 1,  0, 0,        0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0,  0, 0,  0, 0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,  0, 0,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,      0, 1, 7,  0, 1,  0, 0,        0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      1, 1, 3,  0, 0,  0, 0,        0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0,  0, 0,  0, 0,        0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,  0, 0,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,      0, 0, 0,  0, 1,  1, 'h0A5,    0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,      0, 1, 9,  0, 1,  0, 0,        0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,      0, 0, 0,  0, 0,  0, 0,        0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0,  0, 0,  0, 0,        0, 1, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    @(negedge clk);
    start = 0; stop = 0; ld_en = 0; ld_addr = '0; ld_data = '0; br_taken = 0; ir_ready = 1;
    chk("start_ld.mem5", 32'(mem[5]), 32'(word(5)));

    // Asynchronous reset between edges while running
    @(posedge clk);
    #1;
    chk("pre_rst.ir_valid", 32'(ir_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ir_valid", 32'(ir_valid), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.fetch_cnt", 32'(fetch_cnt), 0);
    chk("arst.ir", 32'(ir), 0);
    chk("arst.ir_pc", 32'(ir_pc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) chk($sformatf("arst.mem%0d", a), 32'(mem[a]), 32'(word(a)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("arst.im_a", 32'(im_a), 0);
    @(posedge clk);
    #1;
    chk("arst.fetch_valid", 32'(ir_valid), 1);
    chk("arst.fetch_ir", 32'(ir), 'h0A5);
    chk("arst.fetch_pc", 32'(ir_pc), 0);
    chk("arst.fetch_cnt1", 32'(fetch_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch unit that owns the single port of the 16x13 instruction SRAM (CLK, WR, A, D_IN, Q; Q combinational, write on posedge CLK). It holds the PC, drives the SRAM address, and registers each fetched word into an instruction register (IR). It hands the IR to the decode stage over a valid/ready handshake and accepts branch/jump redirects from execute. While idle it gives a program loader write access to the SRAM.

Parameters:
AW, 4, SRAM address / PC width
DW, 13, instruction width
RESET_PC, 0, PC value after reset and on START
CNT_W, 8, width of the fetch counter

Ports:
CLK  in  1  clock, all state updates on posedge
RST_N  in  1  asynchronous active-low reset
START  in  1  IDLE->RUN; PC <= RESET_PC
STOP  in  1  request to stop fetching; RUN->DRAIN
LD_EN  in  1  loader write strobe, honoured only in IDLE
LD_ADDR  in  AW  loader write address
LD_DATA  in  DW  loader write data
IM_A  out  AW  SRAM address
IM_WR  out  1  SRAM write enable
IM_D  out  DW  SRAM write data
IM_Q  in  DW  SRAM read data (combinational from IM_A)
IR  out  DW  registered instruction
IR_PC  out  AW  address IR was fetched from
IR_VALID  out  1  IR holds an unconsumed instruction
IR_READY  in  1  decode accepts IR this cycle
BR_TAKEN  in  1  redirect request from execute
BR_TARGET  in  AW  redirect address
BUSY  out  1  state != IDLE
FETCH_CNT  out  CNT_W  count of fetches since START, saturating

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, PC=RESET_PC, IR=0, IR_PC=0, IR_VALID=0, FETCH_CNT=0, BUSY=0.
- Combinational outputs: IM_A = LD_ADDR in IDLE, else PC. IM_WR = (state==IDLE) & LD_EN & !START. IM_D = LD_DATA.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Loader writes pass through; BR_TAKEN and IR_READY are ignored.
  - START: next state RUN, PC<=RESET_PC, FETCH_CNT<=0. START overrides a same-cycle LD_EN (no write).
- RUN:
  - Fetch condition: fire = !BR_TAKEN & (!IR_VALID | IR_READY).
  - On fire: IR<=IM_Q, IR_PC<=PC, IR_VALID<=1, PC<=PC+1 (wraps 15->0), FETCH_CNT<=FETCH_CNT+1 (saturates at all-ones).
  - IR_VALID & IR_READY with no fire cannot occur in RUN without BR_TAKEN.
  - BR_TAKEN (priority over everything): PC<=BR_TARGET, IR_VALID<=0 (flush, even if IR_READY is high), no fetch this cycle. The first fetch from the target occurs the following cycle.
  - Latency: IR_VALID rises one cycle after entering RUN. Sustained throughput is 1 instruction/cycle while IR_READY=1. A redirect costs one bubble cycle.
- STOP in RUN: no fetch this cycle.
  - Next state IDLE if IR_VALID would be 0 after the cycle (accepted or flushed), else DRAIN.
  - STOP+BR_TAKEN: PC<=BR_TARGET, IR flushed, go to IDLE. PC retains the target.
- DRAIN:
  - No fetches; PC holds.
  - IR_READY or BR_TAKEN clears IR_VALID. BR_TAKEN also loads PC.
  - Leave for IDLE in the cycle IR_VALID clears. START and STOP are ignored.
- IR, IR_PC and IR_VALID are stable while IR_VALID=1 and IR_READY=0 (no overwrite).
- STOP in IDLE and START in RUN/DRAIN are ignored.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
  - AW/DW defaults
  - opcode constants used by decode/execute (ADD 7'b0000010, DEC 7'b0000110, LOAD 7'b0010000, ADDI 7'b1000010, BRZ 7'b1100000, JUMP 7'b1110000)
- Natural single sub-module: fetch_counter (saturating CNT_W counter with clear and enable).
- PC/IR/FSM stay in instruction_fetch.

Test Plan:
- Reset mid-RUN (RST_N low asynchronously between edges) -> IR_VALID=0, BUSY=0, PC=0 immediately; SRAM contents unchanged.
- In IDLE, load 13'h0A5@0, 13'h1FF@1, 13'h003@2 via LD_EN, then START with IR_READY=1 -> IR_VALID high the next cycle; (IR, IR_PC) sequence = (0A5,0),(1FF,1),(003,2) on consecutive cycles; FETCH_CNT=3.
- Backpressure: IR_READY=0 for 3 cycles after the first fetch -> IR=0A5, IR_PC=0 held, IM_A=1 stable, FETCH_CNT stays 1; the next word is presented one cycle after IR_READY returns to 1.
- Redirect: BR_TAKEN=1, BR_TARGET=11 while IR_VALID=1 and IR_READY=1 -> IR_VALID=0 next cycle; the next fetch has IR_PC=11; then 12, 13.
- Wrap: running from PC=14 -> IR_PC sequence 14, 15, 0; FETCH_CNT with CNT_W=2 saturates at 3.
- STOP with IR_READY=0 -> DRAIN, BUSY=1, no PC change; IR_READY=1 -> IDLE next cycle. A same-cycle START+LD_EN in IDLE -> IM_WR=0, RUN entered.
